mem_stage_ls: RTL

Parametrised MEM pipeline stage for the LoongArch in-order core, sitting between EXE and WB. It is the successor to the fixed one-cycle MEM stage. It waits for a handshaked data-memory response instead of assuming synchronous SRAM read data, and it buffers responses that arrive while WB is stalled. It also performs sub-word load extraction with sign or zero extension, and discards responses belonging to instructions cancelled by a pipeline flush.

---
 rtl/mem_stage_ls_pkg.sv | 31 +++
 rtl/mem_stage_ls_if.sv | 38 +++
 rtl/mem_load_align.sv | 47 ++++
 rtl/mem_stage_ls.sv | 107 ++++++++++
 4 files changed

// File: rtl/mem_stage_ls_pkg.sv
// Shared definitions for the load/store MEM stage: mem_op encodings and bus widths.
// Bus widths are functions of DATA_W so every file sizes the payloads the same way.
package mem_stage_ls_pkg;

  typedef enum logic [2:0] {
    MEM_OP_B   = 3'd0,
    MEM_OP_H   = 3'd1,
    MEM_OP_W   = 3'd2,
    MEM_OP_D   = 3'd3,
    MEM_OP_BU  = 3'd4,
    MEM_OP_HU  = 3'd5,
    MEM_OP_WU  = 3'd6,
    MEM_OP_RSV = 3'd7
  } mem_op_e;

  // {alu_result, res_from_mem, mem_op[3], req_issued, gr_we, dest[5], pc}
  function automatic int exe_to_mem_bus_width(input int dw);
    return 2 * dw + 11;
  endfunction

  // {gr_we, dest[5], final_result, pc}
  function automatic int mem_to_wb_bus_width(input int dw);
    return 2 * dw + 6;
  endfunction

  // {fwd_ready, final_result, gr_we & mem_valid, dest[5]}
  function automatic int mem_to_id_bypass_width(input int dw);
    return dw + 7;
  endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// Pipeline and data-memory response signals around the MEM stage.
// master = the MEM stage itself, slave = surrounding pipeline and memory.
interface mem_stage_ls_if #(
  parameter int DATA_W = 32
);
  import mem_stage_ls_pkg::*;

  localparam int EXE_W = exe_to_mem_bus_width(DATA_W);
  localparam int WB_W  = mem_to_wb_bus_width(DATA_W);
  localparam int BYP_W = mem_to_id_bypass_width(DATA_W);

  logic [EXE_W-1:0]  exe_to_mem_bus;
  logic              exe_to_mem_valid;
  logic              mem_allow_in;
  logic              wb_allow_in;
  logic              mem_to_wb_valid;
  logic [WB_W-1:0]   mem_to_wb_bus;
  logic [BYP_W-1:0]  mem_to_id_bypass_bus;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              flush;
  logic              mem_valid;

  modport master (
    input  exe_to_mem_bus, exe_to_mem_valid, wb_allow_in,
    input  data_sram_data_ok, data_sram_rdata, flush,
    output mem_allow_in, mem_to_wb_valid, mem_to_wb_bus,
    output mem_to_id_bypass_bus, mem_valid
  );

  modport slave (
    output exe_to_mem_bus, exe_to_mem_valid, wb_allow_in,
    output data_sram_data_ok, data_sram_rdata, flush,
    input  mem_allow_in, mem_to_wb_valid, mem_to_wb_bus,
    input  mem_to_id_bypass_bus, mem_valid
  );

endinterface

// File: rtl/mem_load_align.sv
// Sub-word load extraction: shift the addressed lane down, then sign- or zero-extend.
// Misaligned offsets are not checked here; EXE has already raised ALE for them.
module mem_load_align
  import mem_stage_ls_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            raw,
  input  logic [$clog2(DATA_W/8)-1:0]  offset,
  input  logic [2:0]                   mem_op,
  output logic [DATA_W-1:0]            aligned
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] b_ext, h_ext, w_ext, bu_ext, hu_ext, wu_ext;

  assign shifted = raw >> {offset, 3'b000};
  assign b_ext   = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
  assign h_ext   = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
  assign bu_ext  = {{(DATA_W-8){1'b0}}, shifted[7:0]};
  assign hu_ext  = {{(DATA_W-16){1'b0}}, shifted[15:0]};

  // On a 32-bit datapath a word already fills the register, so W/WU/D collapse.
  generate
    if (DATA_W > 32) begin : g_wide
      assign w_ext  = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      assign wu_ext = {{(DATA_W-32){1'b0}}, shifted[31:0]};
    end else begin : g_narrow
      assign w_ext  = shifted;
      assign wu_ext = shifted;
    end
  endgenerate

  always_comb begin
    aligned = shifted;
    case (mem_op_e'(mem_op))
      MEM_OP_B:  aligned = b_ext;
      MEM_OP_H:  aligned = h_ext;
      MEM_OP_W:  aligned = w_ext;
      MEM_OP_BU: aligned = bu_ext;
      MEM_OP_HU: aligned = hu_ext;
      MEM_OP_WU: aligned = wu_ext;
      default:   aligned = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_ls.sv
// MEM pipeline stage waiting on a handshaked data-memory response, with a one-entry
// response buffer for WB stalls and a discard counter for responses of flushed loads.
module mem_stage_ls
  import mem_stage_ls_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DISCARD_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_ls_if.master bus
);

  localparam int EXE_W = exe_to_mem_bus_width(DATA_W);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;

  logic [EXE_W-1:0]     payload_q, payload_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0]    rdata_buf_q, rdata_buf_d;
  logic [DISCARD_W-1:0] discard_cnt_q, discard_cnt_d;

  logic [DATA_W-1:0] alu_result, pc;
  logic              res_from_mem, req_issued, gr_we;
  logic [2:0]        mem_op;
  logic [4:0]        dest;

  assign {alu_result, res_from_mem, mem_op, req_issued, gr_we, dest, pc} = payload_q;

  logic              data_ok_eff, ready_go, fwd_ready, leave, disc_inc, disc_dec;
  logic [DATA_W-1:0] raw_data, aligned_data, final_result;

  // A response only belongs to this instruction once all cancelled ones are drained.
  assign data_ok_eff  = bus.data_sram_data_ok && (discard_cnt_q == '0);
  assign ready_go     = !req_issued || data_ok_eff || buf_valid_q;
  assign fwd_ready    = !res_from_mem || data_ok_eff || buf_valid_q;
  assign leave        = bus.mem_to_wb_valid && bus.wb_allow_in;
  assign disc_inc     = bus.flush && mem_valid_q && req_issued && !buf_valid_q && !data_ok_eff;
  assign disc_dec     = bus.data_sram_data_ok && (discard_cnt_q != '0);

  assign raw_data     = buf_valid_q ? rdata_buf_q : bus.data_sram_rdata;
  assign final_result = res_from_mem ? aligned_data : alu_result;

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .raw     (raw_data),
    .offset  (alu_result[OFF_W-1:0]),
    .mem_op  (mem_op),
    .aligned (aligned_data)
  );

  assign bus.mem_allow_in         = !mem_valid_q || (ready_go && bus.wb_allow_in);
  assign bus.mem_to_wb_valid      = mem_valid_q && ready_go && !bus.flush;
  assign bus.mem_to_wb_bus        = {gr_we, dest, final_result, pc};
  assign bus.mem_to_id_bypass_bus = {fwd_ready, final_result, gr_we & mem_valid_q, dest};
  assign bus.mem_valid            = mem_valid_q;

  always_comb begin
    payload_d     = payload_q;
    mem_valid_d   = mem_valid_q;
    buf_valid_d   = buf_valid_q;
    rdata_buf_d   = rdata_buf_q;
    discard_cnt_d = discard_cnt_q;

    if (bus.mem_allow_in) begin
      payload_d   = bus.exe_to_mem_bus;
      mem_valid_d = bus.exe_to_mem_valid;
    end
    if (bus.flush) begin
      mem_valid_d = 1'b0;
    end

    if (bus.flush || leave) begin
      buf_valid_d = 1'b0;
    end else if (data_ok_eff && mem_valid_q && req_issued && !bus.wb_allow_in) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = bus.data_sram_rdata;
    end

    if (disc_inc && !disc_dec && discard_cnt_q != DISCARD_MAX) begin
      discard_cnt_d = discard_cnt_q + 1'b1;
    end else if (disc_dec && !disc_inc) begin
      discard_cnt_d = discard_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q   <= 1'b0;
      buf_valid_q   <= 1'b0;
      discard_cnt_q <= '0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      buf_valid_q   <= buf_valid_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    payload_q   <= payload_d;
    rdata_buf_q <= rdata_buf_d;
  end

  discard_overflow: assert property (@(posedge clk) disable iff (reset)
    !(disc_inc && !disc_dec && discard_cnt_q == DISCARD_MAX));

endmodule
